led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Parametrised successor to the fixed 8-bit LED counter.
- Internal prescaler produces one step every TICK_DIV clocks. On each step, a WIDTH-bit LED pattern register advances in one of four run-time selectable modes: binary up, binary down, bounce scanner and blink.
- Adds pause, single-step, a step strobe and a wrap strobe.
- Sits between board clock/reset and the LED pins; step and wrap can also feed other status logic.

Parameters:
- WIDTH, 8, number of LEDs. Legal range 2..32.
- TICK_DIV, 250, clocks per pattern step. Must be ≥2. Prescaler width is $clog2(TICK_DIV).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  2  pattern select: 0 up, 1 down, 2 scanner, 3 blink.
- run  input  1  1 = free-running steps; 0 = paused.
- step_req  input  1  single-step request, honoured only while run=0.
- leds  output  WIDTH  registered LED pattern.
- step  output  1  registered 1-cycle strobe, high in the cycle leds shows a newly advanced value.
- wrap  output  1  registered 1-cycle strobe, high together with step when the pattern completes a period.

Behaviour:
- **Reset** (reset=1 at edge):
  - prescaler cnt=0, leds=0, mode_q=0, scan_dir=left.
  - step=0, wrap=0.
  - reset overrides all other inputs.
- **Prescaler:**
  - cnt increments only when run=1.
  - When cnt==TICK_DIV-1, cnt returns to 0 and tick=1 (combinational, internal).
  - cnt holds while run=0.
- **Advance condition:** adv = tick | (~run & step_req).
  - step_req while run=1 is ignored.
  - step_req is level-sampled; holding it high with run=0 advances every cycle.
- **Mode change:** when mode != mode_q at an edge:
  - mode_q<=mode, cnt<=0, scan_dir<=left.
  - leds<=initial value of new mode: up 0, down all-ones, scanner 1 (bit0), blink 0.
  - step=0, wrap=0.
  - Mode reload wins over a coincident adv; no step is taken that cycle.
- **Step action** on adv, using mode_q:
  - Up: leds+1 mod 2^WIDTH. wrap when all-ones→0.
  - Down: leds-1 mod 2^WIDTH. wrap when 0→all-ones.
  - Scanner: exactly one bit set at all times.
    - Direction left: shift left. When the new value has bit WIDTH-1 set, scan_dir<=right.
    - Direction right: shift right. When the new value is bit0, scan_dir<=left and wrap=1.
    - Period is 2·(WIDTH-1) steps. Neither end bit is repeated.
  - Blink: leds<=~leds (all-on/all-off). wrap on the off→on transition.
- **Latency:**
  - adv in cycle N → leds, step (and wrap) update at the edge ending cycle N; they are visible in cycle N+1.
  - step/wrap are 0 in every cycle without a preceding adv.
- **Pause:** run 1→0 freezes cnt and leds mid-interval. run 0→1 resumes counting from the frozen cnt, so the first step after resume arrives after TICK_DIV-cnt clocks.
- **Reset mid-operation:** returns to the reset state on the next edge regardless of mode, cnt or scan_dir.
  - If mode≠0 at that time, the mode-change reload occurs on the following edge.
- **Illegal state guard:** in scanner mode, if leds is not one-hot (e.g. after a mode race), the next adv loads 1 and scan_dir=left, with no wrap.

Test Plan (WIDTH=8, TICK_DIV=4):
1. Reset, mode=0, run=1 → step every 4 clocks; leds 0,1,2,…; after 256 steps leds 0xFF→0x00 with wrap=1 on that step only.
2. mode=1 from reset → reload leds=0xFF one edge after mode seen, no step; first step after 4 clocks gives 0xFE; 0x00→0xFF step asserts wrap.
3. mode=2, run=1 → leds 01,02,…,80,40,…,01; wrap=1 exactly at return to 01 (step 14); sequence repeats; never two bits set.
4. mode=3 → leds 00,FF,00,FF at 4-clock spacing; wrap with each 00→FF step only.
5. Mode 0 running, drop run at cnt=2 → leds frozen for 20 clocks; pulse step_req 3 single cycles → leds +3, step high 3 times; step_req with run=1 → no extra advance; raise run → next step after 2 clocks.
6. Change mode 0→2 in the same cycle cnt==3 → leds=01, step=0, cnt=0; assert reset mid-scan → leds=00, step=wrap=0 next cycle, then reload to 01 on the following edge.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: a prescaler produces one step every TICK_DIV clocks,
// and each step advances a WIDTH-bit LED pattern in one of four modes
// (binary up, binary down, bounce scanner, blink). It also supports pause,
// single-step, a step strobe and a wrap strobe.
module led_pattern_gen #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 250
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             run,
  input  logic             step_req,
  output logic [WIDTH-1:0] leds,
  output logic             step,
  output logic             wrap
);

  localparam int CNT_W = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] LED_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] LED_ALL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] LED_NONE = '0;

  typedef enum logic [1:0] {
    MODE_UP    = 2'd0,
    MODE_DOWN  = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Registered state
  logic [CNT_W-1:0] cnt;
  mode_t            mode_q;
  dir_t             scan_dir;

  // Next-state values
  logic [CNT_W-1:0] cnt_nxt;
  mode_t            mode_nxt;
  dir_t             dir_nxt;
  logic [WIDTH-1:0] leds_nxt;
  logic             step_nxt;
  logic             wrap_nxt;

  // Internal control
  mode_t mode_in;
  logic  mode_chg;
  logic  tick;
  logic  adv;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != LED_NONE) && ((v & (v - LED_ONE)) == LED_NONE);
  endfunction

  // Pattern loaded when a mode is newly selected.
  function automatic logic [WIDTH-1:0] init_pattern(input mode_t m);
    logic [WIDTH-1:0] p;
    case (m)
      MODE_DOWN: p = LED_ALL;
      MODE_SCAN: p = LED_ONE;
      default:   p = LED_NONE;
    endcase
    return p;
  endfunction

  assign mode_in  = mode_t'(mode);
  assign mode_chg = (mode_in != mode_q);
  assign tick     = run && (cnt == CNT_MAX);
  assign adv      = tick || (!run && step_req);

  // State register: reset wins over everything, otherwise take next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      mode_q   <= MODE_UP;
      scan_dir <= DIR_LEFT;
      leds     <= LED_NONE;
      step     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      mode_q   <= mode_nxt;
      scan_dir <= dir_nxt;
      leds     <= leds_nxt;
      step     <= step_nxt;
      wrap     <= wrap_nxt;
    end
  end

  // Next-state logic: mode reload has priority over a coincident advance.
  always_comb begin
    cnt_nxt  = cnt;
    mode_nxt = mode_q;
    dir_nxt  = scan_dir;
    leds_nxt = leds;
    step_nxt = 1'b0;
    wrap_nxt = 1'b0;

    if (mode_chg) begin
      mode_nxt = mode_in;
      cnt_nxt  = '0;
      dir_nxt  = DIR_LEFT;
      leds_nxt = init_pattern(mode_in);
    end else begin
      // Prescaler only moves while running; a pause freezes it mid-interval.
      if (run) begin
        cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
      end

      if (adv) begin
        step_nxt = 1'b1;
        case (mode_q)
          MODE_UP: begin
            leds_nxt = leds + LED_ONE;
            wrap_nxt = (leds == LED_ALL);
          end
          MODE_DOWN: begin
            leds_nxt = leds - LED_ONE;
            wrap_nxt = (leds == LED_NONE);
          end
          MODE_SCAN: begin
            if (!is_onehot(leds)) begin
              // Recover from a corrupted pattern by restarting the scan.
              leds_nxt = LED_ONE;
              dir_nxt  = DIR_LEFT;
            end else if (scan_dir == DIR_LEFT) begin
              leds_nxt = leds << 1;
              if (leds_nxt[WIDTH-1]) begin
                dir_nxt = DIR_RIGHT;
              end
            end else begin
              leds_nxt = leds >> 1;
              if (leds_nxt == LED_ONE) begin
                dir_nxt  = DIR_LEFT;
                wrap_nxt = 1'b1;
              end
            end
          end
          default: begin
            // Blink: a period completes on the off-to-on transition.
            leds_nxt = ~leds;
            wrap_nxt = (leds == LED_NONE);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen (WIDTH=8, TICK_DIV=4): directed scenarios plus a
// randomized phase, compared each cycle against a phase-based reference model.
module tb_led_pattern_gen;

  localparam int W  = 8;
  localparam int TD = 4;
  localparam int SCAN_PERIOD = 2 * (W - 1);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   mode = 2'd0;
  logic         run = 1'b0;
  logic         step_req = 1'b0;
  logic [W-1:0] leds;
  logic         step;
  logic         wrap;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int           m_cnt   = 0;
  int           m_mode  = 0;
  int           m_phase = 0;
  logic [W-1:0] m_leds  = '0;
  logic         m_step  = 1'b0;
  logic         m_wrap  = 1'b0;

  int steps_seen;
  int wraps_seen;
  int wait_cycles;
  logic [W-1:0] saved;

  led_pattern_gen #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .mode(mode), .run(run),
    .step_req(step_req), .leds(leds), .step(step), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] scan_pat(input int p);
    int pos;
    logic [W-1:0] one;
    pos = (p < W) ? p : SCAN_PERIOD - p;
    one = 1;
    return one << pos;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic [1:0] m, input logic rn, input logic sr);
    logic tk, adv;
    if (r) begin
      m_cnt = 0; m_mode = 0; m_phase = 0; m_leds = '0; m_step = 0; m_wrap = 0;
    end else if (int'(m) != m_mode) begin
      m_mode = int'(m); m_cnt = 0; m_phase = 0; m_step = 0; m_wrap = 0;
      m_leds = (m == 2'd1) ? 8'hFF : (m == 2'd2) ? 8'h01 : 8'h00;
    end else begin
      tk  = rn && (m_cnt == TD - 1);
      if (rn) m_cnt = (m_cnt + 1) % TD;
      adv = tk || (!rn && sr);
      m_step = adv;
      m_wrap = 0;
      if (adv) begin
        case (m_mode)
          0: begin m_wrap = (m_leds == 8'hFF); m_leds = m_leds + 8'd1; end
          1: begin m_wrap = (m_leds == 8'h00); m_leds = m_leds - 8'd1; end
          2: begin
            m_phase = (m_phase + 1) % SCAN_PERIOD;
            m_wrap  = (m_phase == 0);
            m_leds  = scan_pat(m_phase);
          end
          default: begin m_wrap = (m_leds == 8'h00); m_leds = ~m_leds; end
        endcase
      end
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare after it.
  task automatic cyc(input logic r, input logic [1:0] m, input logic rn, input logic sr);
    reset = r; mode = m; run = rn; step_req = sr;
    @(posedge clk);
    model_update(r, m, rn, sr);
    #1;
    chk("leds", 32'(leds), 32'(m_leds));
    chk("step", 32'(step), 32'(m_step));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    if (m_mode == 2 && !r) chk("scan_onehot", 32'($countones(leds)), 32'd1);
    if (step) steps_seen++;
    if (wrap) wraps_seen++;
  endtask

  initial begin
    logic [1:0] rm;
    logic rr, rrun, rsr;

    // Reset state
    cyc(1, 0, 0, 0);
    cyc(1, 3, 1, 1);
    chk("reset_leds", 32'(leds), 32'd0);
    chk("reset_step", 32'(step), 32'd0);
    chk("reset_wrap", 32'(wrap), 32'd0);

    // Up count through a full wrap
    steps_seen = 0; wraps_seen = 0;
    for (int i = 0; i < 256 * TD; i++) cyc(0, 0, 1, 0);
    chk("up_steps", 32'(steps_seen), 32'd256);
    chk("up_wraps", 32'(wraps_seen), 32'd1);
    chk("up_final", 32'(leds), 32'd0);

    // Down count: reload, then full wrap
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    chk("down_reload_leds", 32'(leds), 32'hFF);
    chk("down_reload_step", 32'(step), 32'd0);
    steps_seen = 0; wraps_seen = 0;
    for (int i = 0; i < TD; i++) cyc(0, 1, 1, 0);
    chk("down_first", 32'(leds), 32'hFE);
    for (int i = 0; i < 255 * TD; i++) cyc(0, 1, 1, 0);
    chk("down_wraps", 32'(wraps_seen), 32'd1);
    chk("down_final", 32'(leds), 32'hFF);

    // Scanner: two full periods
    cyc(1, 0, 0, 0);
    cyc(0, 2, 1, 0);
    chk("scan_reload", 32'(leds), 32'h01);
    steps_seen = 0; wraps_seen = 0;
    for (int i = 0; i < 2 * SCAN_PERIOD * TD; i++) cyc(0, 2, 1, 0);
    chk("scan_steps", 32'(steps_seen), 32'(2 * SCAN_PERIOD));
    chk("scan_wraps", 32'(wraps_seen), 32'd2);

    // Blink, entered straight from scanner
    cyc(0, 3, 1, 0);
    chk("blink_reload", 32'(leds), 32'h00);
    steps_seen = 0; wraps_seen = 0;
    for (int i = 0; i < 4 * TD; i++) cyc(0, 3, 1, 0);
    chk("blink_steps", 32'(steps_seen), 32'd4);
    chk("blink_wraps", 32'(wraps_seen), 32'd2);

    // Pause, single-step, ignored step_req while running, resume latency
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < 2 * TD && m_cnt != 2; i++) cyc(0, 0, 1, 0);
    saved = leds;
    steps_seen = 0;
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
    chk("pause_frozen", 32'(leds), 32'(saved));
    chk("pause_nostep", 32'(steps_seen), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
    end
    chk("single_steps", 32'(steps_seen), 32'd3);
    chk("single_leds", 32'(leds), 32'(saved + 8'd3));
    wait_cycles = 0;
    steps_seen  = 0;
    for (int i = 0; i < 3 * TD && steps_seen == 0; i++) begin
      cyc(0, 0, 1, 1);
      wait_cycles++;
    end
    chk("resume_latency", 32'(wait_cycles), 32'd2);
    chk("resume_leds", 32'(leds), 32'(saved + 8'd4));

    // Mode change on the tick cycle, then reset mid-scan
    for (int i = 0; i < 2 * TD && m_cnt != 3; i++) cyc(0, 0, 1, 0);
    cyc(0, 2, 1, 0);
    chk("race_leds", 32'(leds), 32'h01);
    chk("race_step", 32'(step), 32'd0);
    for (int i = 0; i < 3 * TD; i++) cyc(0, 2, 1, 0);
    cyc(1, 2, 1, 0);
    chk("midrst_leds", 32'(leds), 32'h00);
    chk("midrst_step", 32'(step), 32'd0);
    chk("midrst_wrap", 32'(wrap), 32'd0);
    cyc(0, 2, 1, 0);
    chk("midrst_reload", 32'(leds), 32'h01);

    // Randomized phase
    rm = 2'd0;
    for (int i = 0; i < 1500; i++) begin
      rr   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 99) < 3) rm = 2'($urandom_range(0, 3));
      rrun = ($urandom_range(0, 99) < 75);
      rsr  = ($urandom_range(0, 1) == 1);
      cyc(rr, rm, rrun, rsr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
